// File: rtl/policy_deck_ctrl_pkg.sv
// Shared op-codes, default deck sizing, FSM states and small hand helpers for the policy deck controller.
// No latency or backpressure of its own; everything here is constant or combinational.
package policy_deck_ctrl_pkg;

    localparam logic [2:0] OP_NEW_GAME = 3'd0;
    localparam logic [2:0] OP_DRAW     = 3'd1;
    localparam logic [2:0] OP_DISCARD  = 3'd2;
    localparam logic [2:0] OP_ENACT    = 3'd3;
    localparam logic [2:0] OP_PEEK     = 3'd4;
    localparam logic [2:0] OP_TOPDECK  = 3'd5;

    localparam logic [4:0] P_N_CARDS   = 5'd17;
    localparam logic [4:0] P_N_ONES    = 5'd6;
    localparam logic [2:0] P_WIN_ONES  = 3'd5;
    localparam logic [2:0] P_WIN_ZEROS = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHUF,
        ST_EXEC,
        ST_RSP
    } state_t;

    function automatic logic [4:0] pop3(input logic [2:0] h);
        return {4'd0, h[0]} + {4'd0, h[1]} + {4'd0, h[2]};
    endfunction

    // Remove card idx and close the gap toward bit0.
    function automatic logic [2:0] drop_card(input logic [2:0] h, input logic [1:0] idx);
        case (idx)
            2'd0:    drop_card = {1'b0, h[2:1]};
            2'd1:    drop_card = {1'b0, h[2], h[0]};
            default: drop_card = {1'b0, h[1:0]};
        endcase
    endfunction

endpackage

// File: rtl/policy_deck_ctrl_if.sv
// Command/response and board-tally bundle between the pin decoder (master) and the deck controller (slave).
// Pure wiring; the slave's cmd_ready carries all backpressure.
interface policy_deck_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_arg;
    logic       rsp_valid;
    logic       rsp_err;
    logic [2:0] rsp_hand;
    logic [1:0] rsp_hand_n;
    logic [4:0] stack_n;
    logic [4:0] discard_n;
    logic [2:0] ones_cnt;
    logic [2:0] zeros_cnt;
    logic       game_over;

    modport master (
        output cmd_valid, cmd_op, cmd_arg,
        input  cmd_ready, rsp_valid, rsp_err, rsp_hand, rsp_hand_n,
        input  stack_n, discard_n, ones_cnt, zeros_cnt, game_over
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg,
        output cmd_ready, rsp_valid, rsp_err, rsp_hand, rsp_hand_n,
        output stack_n, discard_n, ones_cnt, zeros_cnt, game_over
    );
endinterface

// File: rtl/policy_deck_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seed 8'h01; low 5 bits feed the shuffler.
// Advances every cycle, no backpressure.
module policy_deck_ctrl_lfsr8 (
    input  logic       clk,
    input  logic       rst_n,
    output logic [4:0] o_rnd
);
    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign o_rnd = r_lfsr[4:0];

    always_ff @(posedge clk) begin
        if (!rst_n) r_lfsr <= 8'h01;
        else        r_lfsr <= {r_lfsr[6:0], w_fb};
    end
endmodule

// File: rtl/policy_deck_ctrl.sv
// Policy-card deck sequencer: one command at a time, rsp_valid 2 cycles after accept (plus shuffle cycles).
// cmd_ready stays low from accept until the cycle after the response pulse.
module policy_deck_ctrl
    import policy_deck_ctrl_pkg::*;
#(
    parameter logic [4:0] N_CARDS   = P_N_CARDS,
    parameter logic [4:0] N_ONES    = P_N_ONES,
    parameter logic [2:0] WIN_ONES  = P_WIN_ONES,
    parameter logic [2:0] WIN_ZEROS = P_WIN_ZEROS
) (
    input  logic              clk,
    input  logic              rst_n,
    policy_deck_ctrl_if.slave io_bus
);
    state_t             r_state;
    logic               r_cmd_ready, r_rsp_valid, r_rsp_err, r_started, r_err;
    logic [2:0]         r_rsp_hand, r_hand, r_op, r_ones, r_zeros;
    logic [1:0]         r_rsp_hand_n, r_hand_n, r_arg;
    logic [N_CARDS-1:0] r_stack;
    logic [4:0]         r_stack_n, r_stack_ones, r_discard_n, r_discard_ones;
    logic [4:0]         r_rem_total, r_rem_ones, r_pos;
    logic [4:0]         w_rnd;
    logic               w_accept, w_err, w_shuf, w_game_over, w_card;
    logic [2:0]         w_hand_drop;

    policy_deck_ctrl_lfsr8 u_lfsr (.clk(clk), .rst_n(rst_n), .o_rnd(w_rnd));

    assign w_accept    = io_bus.cmd_valid && r_cmd_ready;
    assign w_game_over = (r_ones == WIN_ONES) || (r_zeros == WIN_ZEROS);
    assign w_card      = (r_op == OP_TOPDECK) ? r_stack[0] : r_hand[r_arg];
    assign w_hand_drop = drop_card(r_hand, r_arg);

    // Rejection is decided at accept so a rejected command never triggers a reshuffle.
    always_comb begin
        w_err = (io_bus.cmd_op != OP_NEW_GAME) && (!r_started || w_game_over);
        case (io_bus.cmd_op)
            OP_NEW_GAME, OP_PEEK: ;
            OP_DRAW, OP_TOPDECK:  if (r_hand_n != 2'd0) w_err = 1'b1;
            OP_DISCARD: if (r_hand_n < 2'd2 || io_bus.cmd_arg >= r_hand_n) w_err = 1'b1;
            OP_ENACT:   if (r_hand_n == 2'd0 || io_bus.cmd_arg >= r_hand_n) w_err = 1'b1;
            default:    w_err = 1'b1;
        endcase
        w_shuf = !w_err && ((io_bus.cmd_op == OP_NEW_GAME) ||
                 ((io_bus.cmd_op == OP_DRAW || io_bus.cmd_op == OP_PEEK ||
                   io_bus.cmd_op == OP_TOPDECK) && r_stack_n < 5'd3));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cmd_ready <= 1'b0; r_rsp_valid <= 1'b0; r_rsp_err <= 1'b0;
            r_rsp_hand <= '0; r_rsp_hand_n <= '0; r_started <= 1'b0; r_err <= 1'b0;
            r_op <= '0; r_arg <= '0; r_hand <= '0; r_hand_n <= '0;
            r_stack <= '0; r_stack_n <= '0; r_stack_ones <= '0;
            r_discard_n <= '0; r_discard_ones <= '0; r_ones <= '0; r_zeros <= '0;
            r_rem_total <= '0; r_rem_ones <= '0; r_pos <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_op  <= io_bus.cmd_op;
                        r_arg <= io_bus.cmd_arg;
                        r_err <= w_err;
                        r_state <= w_shuf ? ST_SHUF : ST_EXEC;
                        if (w_shuf) begin
                            r_stack <= '0;
                            r_pos   <= '0;
                            r_discard_n    <= '0;
                            r_discard_ones <= '0;
                            if (io_bus.cmd_op == OP_NEW_GAME) begin
                                r_rem_total <= N_CARDS;  r_stack_n    <= N_CARDS;
                                r_rem_ones  <= N_ONES;   r_stack_ones <= N_ONES;
                                r_hand <= '0; r_hand_n <= '0; r_ones <= '0; r_zeros <= '0;
                            end else begin
                                r_rem_total  <= r_stack_n + r_discard_n;
                                r_stack_n    <= r_stack_n + r_discard_n;
                                r_rem_ones   <= r_stack_ones + r_discard_ones;
                                r_stack_ones <= r_stack_ones + r_discard_ones;
                            end
                        end
                    end
                end
                ST_SHUF: begin
                    // Rejection sampling: out-of-range draws are dropped and the LFSR simply moves on.
                    if (r_rem_total == 5'd0) begin
                        r_state <= ST_EXEC;
                    end else if (w_rnd < r_rem_total) begin
                        r_stack[r_pos] <= (w_rnd < r_rem_ones);
                        r_rem_total    <= r_rem_total - 5'd1;
                        if (w_rnd < r_rem_ones) r_rem_ones <= r_rem_ones - 5'd1;
                        r_pos          <= r_pos + 5'd1;
                    end
                end
                ST_EXEC: begin
                    r_state     <= ST_RSP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= r_err;
                    if (!r_err) begin
                        case (r_op)
                            OP_NEW_GAME: r_started <= 1'b1;
                            OP_DRAW: begin
                                r_hand       <= r_stack[2:0];
                                r_hand_n     <= 2'd3;
                                r_rsp_hand   <= r_stack[2:0];
                                r_rsp_hand_n <= 2'd3;
                                r_stack      <= r_stack >> 3;
                                r_stack_n    <= r_stack_n - 5'd3;
                                r_stack_ones <= r_stack_ones - pop3(r_stack[2:0]);
                            end
                            OP_DISCARD: begin
                                r_hand         <= w_hand_drop;
                                r_hand_n       <= r_hand_n - 2'd1;
                                r_rsp_hand     <= w_hand_drop;
                                r_rsp_hand_n   <= r_hand_n - 2'd1;
                                r_discard_n    <= r_discard_n + 5'd1;
                                r_discard_ones <= r_discard_ones + {4'd0, w_card};
                            end
                            OP_ENACT, OP_TOPDECK: begin
                                if (w_card) begin
                                    if (r_ones != WIN_ONES) r_ones <= r_ones + 3'd1;
                                end else if (r_zeros != WIN_ZEROS) begin
                                    r_zeros <= r_zeros + 3'd1;
                                end
                                if (r_op == OP_ENACT) begin
                                    r_discard_n    <= r_discard_n + {3'd0, r_hand_n} - 5'd1;
                                    r_discard_ones <= r_discard_ones + pop3(r_hand) - {4'd0, w_card};
                                    r_hand <= '0; r_hand_n <= '0;
                                    r_rsp_hand <= '0; r_rsp_hand_n <= '0;
                                end else begin
                                    r_stack      <= r_stack >> 1;
                                    r_stack_n    <= r_stack_n - 5'd1;
                                    r_stack_ones <= r_stack_ones - {4'd0, w_card};
                                end
                            end
                            OP_PEEK: begin
                                r_rsp_hand   <= r_stack[2:0];
                                r_rsp_hand_n <= 2'd3;
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign io_bus.cmd_ready  = r_cmd_ready;
    assign io_bus.rsp_valid  = r_rsp_valid;
    assign io_bus.rsp_err    = r_rsp_err;
    assign io_bus.rsp_hand   = r_rsp_hand;
    assign io_bus.rsp_hand_n = r_rsp_hand_n;
    assign io_bus.stack_n    = r_stack_n;
    assign io_bus.discard_n  = r_discard_n;
    assign io_bus.ones_cnt   = r_ones;
    assign io_bus.zeros_cnt  = r_zeros;
    assign io_bus.game_over  = w_game_over;
endmodule

// File: tb/tb_policy_deck_ctrl.sv
// Directed-plus-random bench for policy_deck_ctrl against a card-counting model of the deck rules.
module tb_policy_deck_ctrl;
    import policy_deck_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    policy_deck_ctrl_if bus ();
    policy_deck_ctrl dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

    int checks = 0;
    int errors = 0;

    // Model: only card counts plus the cards the DUT has revealed.
    bit         m_started;
    int         m_stack_n, m_discard_n, m_discard_ones, m_ones, m_zeros;
    int         m_hand[$];
    bit         m_peek_vld;
    logic [2:0] m_peek;

    int         lat;
    logic       got_err;
    logic [2:0] got_hand;
    logic [1:0] got_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int hand_ones();
        int s = 0;
        foreach (m_hand[i]) s += m_hand[i];
        return s;
    endfunction

    function automatic int stack_ones();
        return 6 - m_ones - m_discard_ones - hand_ones();
    endfunction

    function automatic logic [2:0] pack_hand();
        logic [2:0] h;
        h = '0;
        foreach (m_hand[i]) h[i] = (m_hand[i] != 0);
        return h;
    endfunction

    function automatic int find_card(input int v);
        foreach (m_hand[i]) if (m_hand[i] == v) return i;
        return -1;
    endfunction

    function automatic bit m_over();
        return (m_ones == 5) || (m_zeros == 6);
    endfunction

    task automatic model_clear();
        m_started = 0; m_stack_n = 0; m_discard_n = 0; m_discard_ones = 0;
        m_ones = 0; m_zeros = 0; m_hand = {}; m_peek_vld = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stack"}, 32'(bus.stack_n), 0);
        check({tag, "_disc"}, 32'(bus.discard_n), 0);
        check({tag, "_ones"}, 32'(bus.ones_cnt), 0);
        check({tag, "_zeros"}, 32'(bus.zeros_cnt), 0);
        check({tag, "_over"}, 32'(bus.game_over), 0);
        check({tag, "_rspv"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rsph"}, {27'd0, bus.rsp_err, bus.rsp_hand, bus.rsp_hand_n}, 0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] arg);
        int n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) check("ready_timeout", 0, 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_arg = arg;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'($urandom); bus.cmd_arg = 2'($urandom);
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
        if (lat >= 400) check("rsp_timeout", 0, 1);
        got_err = bus.rsp_err; got_hand = bus.rsp_hand; got_n = bus.rsp_hand_n;
        check("rdy_busy", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        check("rsp_pulse", 32'(bus.rsp_valid), 0);
        check("rdy_back", 32'(bus.cmd_ready), 1);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [1:0] arg);
        bit exp_err, shuf;
        int hs, card, avail, h1;
        hs = m_hand.size();
        exp_err = (op != OP_NEW_GAME) && (!m_started || m_over());
        case (op)
            OP_DRAW, OP_TOPDECK: if (hs != 0) exp_err = 1;
            OP_DISCARD: if (hs < 2 || int'(arg) >= hs) exp_err = 1;
            OP_ENACT:   if (hs == 0 || int'(arg) >= hs) exp_err = 1;
            OP_NEW_GAME, OP_PEEK: ;
            default: exp_err = 1;
        endcase
        shuf = !exp_err && (op == OP_NEW_GAME ||
               ((op == OP_DRAW || op == OP_PEEK || op == OP_TOPDECK) && m_stack_n < 3));
        issue(op, arg);
        check("rsp_err", 32'(got_err), 32'(exp_err));
        if (!exp_err) begin
            if (shuf) begin
                m_peek_vld = 0;
                if (op == OP_NEW_GAME) begin model_clear(); m_stack_n = 17; end
                else begin m_stack_n += m_discard_n; m_discard_n = 0; m_discard_ones = 0; end
            end
            avail = stack_ones();
            h1 = int'(got_hand[0]) + int'(got_hand[1]) + int'(got_hand[2]);
            case (op)
                OP_NEW_GAME: m_started = 1;
                OP_DRAW: begin
                    check("draw_n", 32'(got_n), 3);
                    check("draw_deal", 32'((h1 <= avail) && (3 - h1 <= m_stack_n - avail)), 1);
                    if (m_peek_vld) check("draw_vs_peek", 32'(got_hand), 32'(m_peek));
                    m_hand = {};
                    for (int i = 0; i < 3; i++) m_hand.push_back(int'(got_hand[i]));
                    m_stack_n -= 3;
                    m_peek_vld = 0;
                end
                OP_DISCARD: begin
                    card = m_hand[arg];
                    m_hand.delete(int'(arg));
                    m_discard_n++; m_discard_ones += card;
                    check("disc_hand", 32'(got_hand), 32'(pack_hand()));
                    check("disc_n", 32'(got_n), m_hand.size());
                end
                OP_ENACT: begin
                    card = m_hand[arg];
                    m_discard_n += hs - 1;
                    m_discard_ones += hand_ones() - card;
                    if (card != 0) m_ones++; else m_zeros++;
                    m_hand = {};
                    check("enact_n", 32'(got_n), 0);
                end
                OP_PEEK: begin
                    check("peek_n", 32'(got_n), 3);
                    check("peek_deal", 32'(h1 <= avail), 1);
                    if (m_peek_vld) check("peek_stable", 32'(got_hand), 32'(m_peek));
                    m_peek = got_hand; m_peek_vld = 1;
                end
                default: begin
                    card = int'(m_peek[0]);
                    if (card != 0) m_ones++; else m_zeros++;
                    m_stack_n--;
                    m_peek_vld = 0;
                end
            endcase
        end
        check("stack_n", 32'(bus.stack_n), m_stack_n);
        check("discard_n", 32'(bus.discard_n), m_discard_n);
        check("ones_cnt", 32'(bus.ones_cnt), m_ones);
        check("zeros_cnt", 32'(bus.zeros_cnt), m_zeros);
        check("game_over", 32'(bus.game_over), 32'(m_over()));
    endtask

    initial begin
        int k, iter;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_arg = '0;
        model_clear();

        // 1: reset state, NEW_GAME, random DRAW/ENACT rounds
        @(negedge clk); @(negedge clk);
        check_all_zero("rst");
        check("rst_rdy_low", 32'(bus.cmd_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rdy", 32'(bus.cmd_ready), 1);
        cmd(OP_DRAW, 2'd0);
        cmd(OP_NEW_GAME, 2'd0);
        check("t1_stack", 32'(bus.stack_n), 17);
        for (int r = 0; r < 6; r++) begin
            cmd(OP_DRAW, 2'd0);
            cmd(OP_ENACT, 2'($urandom_range(0, 2)));
        end

        // 2: one round with exact latency
        cmd(OP_NEW_GAME, 2'd0);
        cmd(OP_DRAW, 2'd0);
        check("t2_latency", 32'(lat), 2);
        cmd(OP_DISCARD, 2'd0);
        cmd(OP_ENACT, 2'd0);
        check("t2_stack", 32'(bus.stack_n), 14);
        check("t2_disc", 32'(bus.discard_n), 2);
        check("t2_enacted", 32'(bus.ones_cnt) + 32'(bus.zeros_cnt), 1);
        check("t2_hand_n", 32'(got_n), 0);

        // 3: rejected commands
        cmd(OP_DISCARD, 2'd0);
        cmd(OP_DRAW, 2'd0);
        cmd(OP_DISCARD, 2'($urandom_range(0, 2)));
        cmd(OP_ENACT, 2'd2);
        cmd(3'd6, 2'd0);
        cmd(3'd7, 2'd1);
        cmd(OP_ENACT, 2'($urandom_range(0, 1)));

        // 4: five rounds then reshuffling DRAW
        cmd(OP_NEW_GAME, 2'd0);
        for (int r = 0; r < 5; r++) begin
            cmd(OP_DRAW, 2'd0);
            k = find_card(1);
            cmd(OP_DISCARD, (k < 0) ? 2'd0 : 2'(k));
            k = find_card(0);
            cmd(OP_ENACT, (k < 0) ? 2'd0 : 2'(k));
        end
        check("t4_stack_pre", 32'(bus.stack_n), 2);
        check("t4_disc_pre", 32'(bus.discard_n), 10);
        cmd(OP_DRAW, 2'd0);
        check("t4_stack", 32'(bus.stack_n), 9);
        check("t4_disc", 32'(bus.discard_n), 0);
        check("t4_hand_n", 32'(got_n), 3);

        // 5: drive toward zeros_cnt=6 via TOPDECK/ENACT
        iter = 0;
        while (!m_over() && iter < 60) begin
            iter++;
            if (m_hand.size() == 0) begin
                cmd(OP_PEEK, 2'd0);
                if (m_peek[0] == 1'b0) begin
                    cmd(OP_TOPDECK, 2'd0);
                    continue;
                end
                cmd(OP_DRAW, 2'd0);
            end
            k = find_card(1);
            if (k >= 0 && m_hand.size() >= 2) cmd(OP_DISCARD, 2'(k));
            k = find_card(0);
            cmd(OP_ENACT, (k < 0) ? 2'd0 : 2'(k));
        end
        check("t5_over", 32'(bus.game_over), 1);
        cmd(OP_DRAW, 2'd0);
        cmd(OP_PEEK, 2'd0);
        cmd(OP_NEW_GAME, 2'd0);
        check("t5_cleared", {26'd0, bus.ones_cnt, bus.zeros_cnt}, 0);
        check("t5_over_clr", 32'(bus.game_over), 0);

        // 6: reset in the middle of a shuffle
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_NEW_GAME; bus.cmd_arg = 2'd0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        check("t6_busy", 32'(bus.cmd_ready), 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("t6");
        @(negedge clk);
        check("t6_rdy", 32'(bus.cmd_ready), 1);
        check_all_zero("t6b");
        model_clear();
        cmd(OP_DRAW, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
